cache_ctrl_2way: RTL and testbench
==================================

Name: cache_ctrl_2way

Overview:
- Parametrised successor to the single-state-machine cache controller.
- Two-way set-associative, single-word-line cache controller placed between the CPU request port and the memory bus master port.
- Holds tag, valid, dirty, data and LRU state internally.
- Supports write-back/write-allocate or write-through/no-write-allocate, chosen by parameter; propagates memory bus errors to the CPU.

Parameters:
ADDR_W, 16, word address width
DATA_W, 32, data word width
SETS, 16, number of sets (power of 2, >=2); IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W
WRITE_BACK, 1, 1 = write-back + write-allocate; 0 = write-through + no-write-allocate

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_cpu_i  in  1  CPU request; held with adr/dat/we stable until ack or err
we_cpu_i  in  1  1 = write, 0 = read
adr_cpu_i  in  ADDR_W  word address
dat_cpu_i  in  DATA_W  write data
dat_cpu_o  out  DATA_W  read data, valid while ack_cpu_o=1
ack_cpu_o  out  1  one-cycle completion pulse
err_cpu_o  out  1  one-cycle error pulse (instead of ack)
cyc_m2s  out  1  memory cycle active
we_m2s  out  1  memory write enable
adr_m2s  out  ADDR_W  memory address
dat_m2s  out  DATA_W  memory write data
dat_mem_i  in  DATA_W  memory read data, valid with ack_mem_i
ack_mem_i  in  1  memory completion, single-cycle pulse
err_mem_i  in  1  memory error, single-cycle pulse, mutually exclusive with ack

Behaviour:
- Reset (rst=0, async): all outputs 0; every valid, dirty and lru bit cleared; FSM to IDLE. Any in-flight transaction is abandoned, with no cache update.
- Address split: index = adr[IDX_W-1:0], tag = adr[ADDR_W-1:IDX_W]. Hit = valid and tag match in either way. Both ways matching cannot occur.
- Outputs are registered. States: IDLE, WB, FILL, WT, RESP.
- IDLE, no request: all outputs held at 0.
- IDLE with req_cpu_i sampled:
  - Read hit: dat_cpu_o = way data, go to RESP. ack is high the cycle after the request edge (1-cycle latency).
  - Write hit, WRITE_BACK=1: update data, set dirty, go to RESP.
  - Write hit, WRITE_BACK=0: update data, go to WT.
  - Read miss, or write miss with WRITE_BACK=1:
    - Victim = first invalid way (way0 before way1), else way lru[set].
    - If WRITE_BACK=1 and victim is valid and dirty: go to WB.
    - Otherwise: go to FILL.
  - Write miss, WRITE_BACK=0: go to WT; no allocation.
- WB:
  - Drive cyc=1, we=1, adr={victim tag,index}, dat=victim data.
  - On ack_mem_i: clear dirty, go to FILL; cyc stays 1 and we/adr update on the same edge.
- FILL:
  - Drive cyc=1, we=0, adr=adr_cpu_i.
  - On ack_mem_i: install victim way with valid=1 and tag.
  - Read: data = dat_mem_i, dat_cpu_o = dat_mem_i, dirty=0.
  - Write: data = dat_cpu_i, dirty=1.
  - Then go to RESP with cyc=0.
- WT:
  - Drive cyc=1, we=1, adr=adr_cpu_i, dat=dat_cpu_i.
  - On ack_mem_i: go to RESP.
- RESP: ack_cpu_o=1 for exactly one cycle. req_cpu_i is ignored in this cycle; return to IDLE.
- Error: err_mem_i in WB, FILL or WT: cyc=0, err_cpu_o=1 for one cycle, return to IDLE. No cache change from the failing beat; a victim not yet written back stays dirty.
- LRU: on a hit or a completed fill, lru[set] points to the other way. Write-through misses do not touch LRU.
- ack_mem_i or err_mem_i outside WB/FILL/WT: ignored.
- Back-to-back requests: a new request is accepted in the cycle after RESP.
- Throughput: hit = 2 cycles request-to-request. Miss latency = memory latency + 1 cycle per memory beat + 1 cycle.

Test Plan:
- Cold read miss and rehit (WRITE_BACK=1, default params):
  - Stimulus: release reset, read 0x0013; memory acks 0xDEADBEEF 3 cycles after cyc.
  - Required: cyc=1, we=0, adr=0x0013; ack_cpu_o with dat_cpu_o=0xDEADBEEF 1 cycle after ack_mem_i.
  - Then read 0x0013: ack 1 cycle after request, cyc stays 0.
- Dirty eviction with LRU:
  - Stimulus: write 0x0003=0x11111111, write 0x0103=0x22222222 (both allocate), read 0x0003 (hit), read 0x0203.
  - Required: WB beat adr=0x0103, dat=0x22222222, we=1; then FILL adr=0x0203.
  - Then read 0x0003: hit, no cyc.
- Write-through (WRITE_BACK=0):
  - Stimulus: write 0x0040=0xA5A5A5A5 (miss).
  - Required: single memory write adr=0x0040; ack after ack_mem_i.
  - Then read 0x0040: misses (no allocation).
- Memory error:
  - Stimulus: err_mem_i during FILL for 0x0020.
  - Required: err_cpu_o pulse, no ack_cpu_o, cyc drops.
  - Then read 0x0020: misses again.
- Reset mid-operation:
  - Stimulus: rst=0 asynchronously while FILL for 0x0013 is waiting.
  - Required: cyc_m2s, ack_cpu_o, err_cpu_o = 0 before the next clock edge.
  - After release, a previously cached address misses.
- Clean eviction:
  - Stimulus: fill 0x0005 and 0x0105 by reads, then read 0x0205.
  - Required: no WB beat; FILL adr=0x0205 replaces way0 (LRU).

Source files
------------

// File: rtl/cache_ctrl_2way.sv
// rtl/cache_ctrl_2way.sv - two-way set-associative single-word-line cache controller
module cache_ctrl_2way #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int SETS       = 16,
   parameter int WRITE_BACK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_cpu_i,
   input  logic              we_cpu_i,
   input  logic [ADDR_W-1:0] adr_cpu_i,
   input  logic [DATA_W-1:0] dat_cpu_i,
   output logic [DATA_W-1:0] dat_cpu_o,
   output logic              ack_cpu_o,
   output logic              err_cpu_o,
   output logic              cyc_m2s,
   output logic              we_m2s,
   output logic [ADDR_W-1:0] adr_m2s,
   output logic [DATA_W-1:0] dat_m2s,
   input  logic [DATA_W-1:0] dat_mem_i,
   input  logic              ack_mem_i,
   input  logic              err_mem_i
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W;
   localparam bit WB_EN = (WRITE_BACK != 0);

   typedef enum logic [2:0] {IDLE, WB, FILL, WT, RESP} state_t;

   state_t state;

   logic [TAG_W-1:0]  tag_mem  [2][SETS];
   logic [DATA_W-1:0] data_mem [2][SETS];
   logic [1:0][SETS-1:0] valid;
   logic [1:0][SETS-1:0] dirty;
   logic [SETS-1:0]   lru;
   logic              vic;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              hit0, hit1, hit, hit_way;
   logic              victim, victim_dirty;

   assign idx          = adr_cpu_i[IDX_W-1:0];
   assign tag          = adr_cpu_i[ADDR_W-1:IDX_W];
   assign hit0         = valid[0][idx] && (tag_mem[0][idx] == tag);
   assign hit1         = valid[1][idx] && (tag_mem[1][idx] == tag);
   assign hit          = hit0 || hit1;
   assign hit_way      = hit1;
   assign victim       = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);
   assign victim_dirty = valid[victim][idx] && dirty[victim][idx];

   logic              mem_we, tag_we, mem_way;
   logic [DATA_W-1:0] mem_wdata;

   // Array writes: CPU write hits in IDLE, line install on a successful fill beat.
   always_comb begin
      mem_we    = 1'b0;
      tag_we    = 1'b0;
      mem_way   = hit_way;
      mem_wdata = dat_cpu_i;
      if (state == IDLE && req_cpu_i && we_cpu_i && hit) begin
         mem_we = 1'b1;
      end else if (state == FILL && ack_mem_i && !err_mem_i) begin
         mem_we    = 1'b1;
         tag_we    = 1'b1;
         mem_way   = vic;
         mem_wdata = we_cpu_i ? dat_cpu_i : dat_mem_i;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) data_mem[mem_way][idx] <= mem_wdata;
      if (tag_we) tag_mem[mem_way][idx]  <= tag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         vic       <= 1'b0;
         valid     <= '0;
         dirty     <= '0;
         lru       <= '0;
         dat_cpu_o <= '0;
         ack_cpu_o <= 1'b0;
         err_cpu_o <= 1'b0;
         cyc_m2s   <= 1'b0;
         we_m2s    <= 1'b0;
         adr_m2s   <= '0;
         dat_m2s   <= '0;
      end else begin
         ack_cpu_o <= 1'b0;
         err_cpu_o <= 1'b0;
         dat_cpu_o <= '0;
         if ((state == WB || state == FILL || state == WT) && err_mem_i) begin
            // Failing beat leaves the arrays untouched; a pending victim stays dirty.
            err_cpu_o <= 1'b1;
            cyc_m2s   <= 1'b0;
            we_m2s    <= 1'b0;
            adr_m2s   <= '0;
            dat_m2s   <= '0;
            state     <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (req_cpu_i) begin
                     if (hit) lru[idx] <= ~hit_way;
                     if (we_cpu_i && !WB_EN) begin
                        cyc_m2s <= 1'b1;
                        we_m2s  <= 1'b1;
                        adr_m2s <= adr_cpu_i;
                        dat_m2s <= dat_cpu_i;
                        state   <= WT;
                     end else if (hit) begin
                        if (we_cpu_i) dirty[hit_way][idx] <= 1'b1;
                        else          dat_cpu_o <= data_mem[hit_way][idx];
                        ack_cpu_o <= 1'b1;
                        state     <= RESP;
                     end else begin
                        vic     <= victim;
                        cyc_m2s <= 1'b1;
                        if (WB_EN && victim_dirty) begin
                           we_m2s  <= 1'b1;
                           adr_m2s <= {tag_mem[victim][idx], idx};
                           dat_m2s <= data_mem[victim][idx];
                           state   <= WB;
                        end else begin
                           we_m2s  <= 1'b0;
                           adr_m2s <= adr_cpu_i;
                           state   <= FILL;
                        end
                     end
                  end
               end
               WB: begin
                  if (ack_mem_i) begin
                     dirty[vic][idx] <= 1'b0;
                     we_m2s  <= 1'b0;
                     adr_m2s <= adr_cpu_i;
                     dat_m2s <= '0;
                     state   <= FILL;
                  end
               end
               FILL: begin
                  if (ack_mem_i) begin
                     valid[vic][idx] <= 1'b1;
                     dirty[vic][idx] <= we_cpu_i;
                     lru[idx]        <= ~vic;
                     dat_cpu_o       <= we_cpu_i ? '0 : dat_mem_i;
                     ack_cpu_o       <= 1'b1;
                     cyc_m2s         <= 1'b0;
                     adr_m2s         <= '0;
                     state           <= RESP;
                  end
               end
               WT: begin
                  if (ack_mem_i) begin
                     ack_cpu_o <= 1'b1;
                     cyc_m2s   <= 1'b0;
                     we_m2s    <= 1'b0;
                     adr_m2s   <= '0;
                     dat_m2s   <= '0;
                     state     <= RESP;
                  end
               end
               RESP:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// tb/tb_cache_ctrl_2way.sv - directed bench for cache_ctrl_2way (write-back and write-through instances)
module tb_cache_ctrl_2way;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sel;
   logic        req, we;
   logic [15:0] adr;
   logic [31:0] dat;
   logic [31:0] mem_rdata;
   logic        mem_ack, mem_err;

   logic        req_wb, req_wt;
   logic [31:0] wb_dat_cpu, wt_dat_cpu, wb_dat_m, wt_dat_m;
   logic        wb_ack, wt_ack, wb_err, wt_err, wb_cyc, wt_cyc, wb_we_m, wt_we_m;
   logic [15:0] wb_adr_m, wt_adr_m;

   assign req_wb = req & ~sel;
   assign req_wt = req & sel;

   logic [31:0] dat_cpu, dat_m;
   logic        ack_cpu, err_cpu, cyc, we_m;
   logic [15:0] adr_m;
   assign dat_cpu = sel ? wt_dat_cpu : wb_dat_cpu;
   assign ack_cpu = sel ? wt_ack     : wb_ack;
   assign err_cpu = sel ? wt_err     : wb_err;
   assign cyc     = sel ? wt_cyc     : wb_cyc;
   assign we_m    = sel ? wt_we_m    : wb_we_m;
   assign adr_m   = sel ? wt_adr_m   : wb_adr_m;
   assign dat_m   = sel ? wt_dat_m   : wb_dat_m;

   cache_ctrl_2way #(.WRITE_BACK(1)) u_wb (
      .clk(clk), .rst(rst), .req_cpu_i(req_wb), .we_cpu_i(we), .adr_cpu_i(adr), .dat_cpu_i(dat),
      .dat_cpu_o(wb_dat_cpu), .ack_cpu_o(wb_ack), .err_cpu_o(wb_err),
      .cyc_m2s(wb_cyc), .we_m2s(wb_we_m), .adr_m2s(wb_adr_m), .dat_m2s(wb_dat_m),
      .dat_mem_i(mem_rdata), .ack_mem_i(mem_ack), .err_mem_i(mem_err)
   );

   cache_ctrl_2way #(.WRITE_BACK(0)) u_wt (
      .clk(clk), .rst(rst), .req_cpu_i(req_wt), .we_cpu_i(we), .adr_cpu_i(adr), .dat_cpu_i(dat),
      .dat_cpu_o(wt_dat_cpu), .ack_cpu_o(wt_ack), .err_cpu_o(wt_err),
      .cyc_m2s(wt_cyc), .we_m2s(wt_we_m), .adr_m2s(wt_adr_m), .dat_m2s(wt_dat_m),
      .dat_mem_i(mem_rdata), .ack_mem_i(mem_ack), .err_mem_i(mem_err)
   );

   int checks = 0;
   int failures = 0;

   int          n_beats, ack_cnt, mem_cnt;
   logic        b_we  [4];
   logic [15:0] b_adr [4];
   logic [31:0] b_dat [4];
   logic        got_ack, got_err, cyc_seen, err_cyc;
   logic [31:0] got_data;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One CPU transaction with a memory responder acking each beat lat cycles after it starts.
   task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input int lat, input int err_beat, input logic [31:0] rd);
      int wait_cnt;
      n_beats = 0; got_ack = 0; got_err = 0; got_data = '0; cyc_seen = 0; err_cyc = 0;
      ack_cnt = 0; mem_cnt = 0; wait_cnt = 0;
      @(negedge clk);
      req = 1'b1; we = w; adr = a; dat = d;
      for (int cnt = 1; cnt <= 60; cnt++) begin
         @(negedge clk);
         mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
         if (ack_cpu) begin
            got_ack = 1; got_data = dat_cpu; ack_cnt = cnt;
            break;
         end
         if (err_cpu) begin
            got_err = 1; err_cyc = cyc;
            break;
         end
         if (cyc) begin
            cyc_seen = 1;
            if (wait_cnt == 0 && n_beats < 4) begin
               b_we[n_beats] = we_m; b_adr[n_beats] = adr_m; b_dat[n_beats] = dat_m;
               n_beats++;
            end
            if (wait_cnt >= lat) begin
               if (n_beats - 1 == err_beat) mem_err = 1'b1;
               else begin mem_ack = 1'b1; mem_rdata = rd; end
               wait_cnt = 0;
               mem_cnt = cnt;
            end else begin
               wait_cnt++;
            end
         end
      end
      req = 1'b0; we = 1'b0; adr = '0; dat = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({wb_cyc, wb_ack, wb_err, wb_we_m, wb_adr_m, wb_dat_m, wb_dat_cpu} !== '0) begin
         failures++; $display("FAIL reset_wb outputs nonzero cyc=%b ack=%b err=%b adr=%h", wb_cyc, wb_ack, wb_err, wb_adr_m);
      end
      checks++;
      if ({wt_cyc, wt_ack, wt_err, wt_we_m, wt_adr_m, wt_dat_m, wt_dat_cpu} !== '0) begin
         failures++; $display("FAIL reset_wt outputs nonzero cyc=%b ack=%b err=%b adr=%h", wt_cyc, wt_ack, wt_err, wt_adr_m);
      end
      rst = 1'b1;
   endtask

   task automatic test_cold_miss();
      sel = 1'b0; do_reset();
      xfer(1'b0, 16'h0013, '0, 3, -1, 32'hDEADBEEF);
      checks++;
      if (n_beats !== 1 || b_we[0] !== 1'b0 || b_adr[0] !== 16'h0013) begin
         failures++; $display("FAIL cold_fill_beat beats=%0d we=%b adr=%h expected 1/0/0013", n_beats, b_we[0], b_adr[0]);
      end
      checks++;
      if (got_ack !== 1'b1 || got_data !== 32'hDEADBEEF) begin
         failures++; $display("FAIL cold_rdata ack=%b data=%h expected 1/deadbeef", got_ack, got_data);
      end
      checks++;
      if (ack_cnt !== 5 || ack_cnt - mem_cnt !== 1) begin
         failures++; $display("FAIL cold_latency ack_cnt=%0d mem_cnt=%0d expected 5/4", ack_cnt, mem_cnt);
      end
      @(negedge clk);
      checks++;
      if (ack_cpu !== 1'b0) begin
         failures++; $display("FAIL ack_single_pulse ack=%b expected 0", ack_cpu);
      end
      xfer(1'b0, 16'h0013, '0, 3, -1, 32'h0);
      checks++;
      if (cyc_seen !== 1'b0 || ack_cnt !== 1 || got_data !== 32'hDEADBEEF) begin
         failures++; $display("FAIL rehit cyc=%b ack_cnt=%0d data=%h expected 0/1/deadbeef", cyc_seen, ack_cnt, got_data);
      end
   endtask

   task automatic test_back_to_back();
      xfer(1'b0, 16'h0013, '0, 1, -1, 32'h0);
      xfer(1'b0, 16'h0013, '0, 1, -1, 32'h0);
      checks++;
      if (cyc_seen !== 1'b0 || ack_cnt !== 1 || got_data !== 32'hDEADBEEF) begin
         failures++; $display("FAIL back_to_back_hit cyc=%b ack_cnt=%0d data=%h expected 0/1/deadbeef", cyc_seen, ack_cnt, got_data);
      end
   endtask

   task automatic test_dirty_eviction();
      sel = 1'b0; do_reset();
      xfer(1'b1, 16'h0003, 32'h11111111, 1, -1, 32'hBAD0BAD0);
      checks++;
      if (got_ack !== 1'b1 || n_beats !== 1 || b_we[0] !== 1'b0 || b_adr[0] !== 16'h0003) begin
         failures++; $display("FAIL wmiss_alloc ack=%b beats=%0d we=%b adr=%h expected 1/1/0/0003", got_ack, n_beats, b_we[0], b_adr[0]);
      end
      xfer(1'b1, 16'h0103, 32'h22222222, 1, -1, 32'hBAD1BAD1);
      xfer(1'b0, 16'h0003, '0, 1, -1, 32'h0);
      checks++;
      if (cyc_seen !== 1'b0 || got_data !== 32'h11111111) begin
         failures++; $display("FAIL whit_read cyc=%b data=%h expected 0/11111111", cyc_seen, got_data);
      end
      xfer(1'b0, 16'h0203, '0, 2, -1, 32'h33333333);
      checks++;
      if (n_beats !== 2 || b_we[0] !== 1'b1 || b_adr[0] !== 16'h0103 || b_dat[0] !== 32'h22222222) begin
         failures++; $display("FAIL wb_beat beats=%0d we=%b adr=%h dat=%h expected 2/1/0103/22222222", n_beats, b_we[0], b_adr[0], b_dat[0]);
      end
      checks++;
      if (b_we[1] !== 1'b0 || b_adr[1] !== 16'h0203 || got_data !== 32'h33333333) begin
         failures++; $display("FAIL wb_then_fill we=%b adr=%h data=%h expected 0/0203/33333333", b_we[1], b_adr[1], got_data);
      end
      xfer(1'b0, 16'h0003, '0, 1, -1, 32'h0);
      checks++;
      if (cyc_seen !== 1'b0 || got_data !== 32'h11111111) begin
         failures++; $display("FAIL lru_kept_way0 cyc=%b data=%h expected 0/11111111", cyc_seen, got_data);
      end
      xfer(1'b0, 16'h0103, '0, 1, -1, 32'h22222222);
      checks++;
      if (cyc_seen !== 1'b1 || n_beats !== 1 || b_we[0] !== 1'b0) begin
         failures++; $display("FAIL evicted_clean_refill cyc=%b beats=%0d we=%b expected 1/1/0", cyc_seen, n_beats, b_we[0]);
      end
   endtask

   task automatic test_write_through();
      sel = 1'b1; do_reset();
      xfer(1'b1, 16'h0040, 32'hA5A5A5A5, 2, -1, 32'h0);
      checks++;
      if (n_beats !== 1 || b_we[0] !== 1'b1 || b_adr[0] !== 16'h0040 || b_dat[0] !== 32'hA5A5A5A5) begin
         failures++; $display("FAIL wt_beat beats=%0d we=%b adr=%h dat=%h expected 1/1/0040/a5a5a5a5", n_beats, b_we[0], b_adr[0], b_dat[0]);
      end
      checks++;
      if (got_ack !== 1'b1 || ack_cnt - mem_cnt !== 1) begin
         failures++; $display("FAIL wt_ack ack=%b gap=%0d expected 1/1", got_ack, ack_cnt - mem_cnt);
      end
      xfer(1'b0, 16'h0040, '0, 1, -1, 32'h00000077);
      checks++;
      if (cyc_seen !== 1'b1 || b_we[0] !== 1'b0 || got_data !== 32'h00000077) begin
         failures++; $display("FAIL wt_no_alloc cyc=%b we=%b data=%h expected 1/0/00000077", cyc_seen, b_we[0], got_data);
      end
      xfer(1'b1, 16'h0040, 32'h12345678, 1, -1, 32'h0);
      xfer(1'b0, 16'h0040, '0, 1, -1, 32'h0);
      checks++;
      if (cyc_seen !== 1'b0 || got_data !== 32'h12345678) begin
         failures++; $display("FAIL wt_hit_update cyc=%b data=%h expected 0/12345678", cyc_seen, got_data);
      end
      sel = 1'b0;
   endtask

   task automatic test_mem_error();
      sel = 1'b0; do_reset();
      xfer(1'b0, 16'h0020, '0, 1, 0, 32'h0);
      checks++;
      if (got_err !== 1'b1 || got_ack !== 1'b0 || err_cyc !== 1'b0) begin
         failures++; $display("FAIL err_pulse err=%b ack=%b cyc=%b expected 1/0/0", got_err, got_ack, err_cyc);
      end
      @(negedge clk);
      checks++;
      if (err_cpu !== 1'b0 || cyc !== 1'b0) begin
         failures++; $display("FAIL err_single err=%b cyc=%b expected 0/0", err_cpu, cyc);
      end
      xfer(1'b0, 16'h0020, '0, 1, -1, 32'h20202020);
      checks++;
      if (cyc_seen !== 1'b1 || got_data !== 32'h20202020) begin
         failures++; $display("FAIL err_no_install cyc=%b data=%h expected 1/20202020", cyc_seen, got_data);
      end
   endtask

   task automatic test_reset_mid_fill();
      sel = 1'b0; do_reset();
      xfer(1'b0, 16'h0005, '0, 1, -1, 32'h55555555);
      @(negedge clk);
      req = 1'b1; we = 1'b0; adr = 16'h0013;
      for (int i = 0; i < 10 && !cyc; i++) @(negedge clk);
      checks++;
      if (cyc !== 1'b1) begin
         failures++; $display("FAIL mid_fill_cyc cyc=%b expected 1", cyc);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({cyc, ack_cpu, err_cpu} !== 3'b000) begin
         failures++; $display("FAIL async_reset cyc/ack/err=%b expected 000", {cyc, ack_cpu, err_cpu});
      end
      @(negedge clk);
      req = 1'b0; adr = '0; rst = 1'b1;
      xfer(1'b0, 16'h0005, '0, 1, -1, 32'h55555555);
      checks++;
      if (cyc_seen !== 1'b1 || got_data !== 32'h55555555) begin
         failures++; $display("FAIL reset_invalidates cyc=%b data=%h expected 1/55555555", cyc_seen, got_data);
      end
   endtask

   task automatic test_clean_eviction();
      sel = 1'b0; do_reset();
      xfer(1'b0, 16'h0005, '0, 1, -1, 32'h00000005);
      xfer(1'b0, 16'h0105, '0, 1, -1, 32'h00000105);
      xfer(1'b0, 16'h0205, '0, 1, -1, 32'h00000205);
      checks++;
      if (n_beats !== 1 || b_we[0] !== 1'b0 || b_adr[0] !== 16'h0205 || got_data !== 32'h00000205) begin
         failures++; $display("FAIL clean_evict beats=%0d we=%b adr=%h data=%h expected 1/0/0205/00000205", n_beats, b_we[0], b_adr[0], got_data);
      end
      xfer(1'b0, 16'h0105, '0, 1, -1, 32'h0);
      checks++;
      if (cyc_seen !== 1'b0 || got_data !== 32'h00000105) begin
         failures++; $display("FAIL way1_kept cyc=%b data=%h expected 0/00000105", cyc_seen, got_data);
      end
      xfer(1'b0, 16'h0005, '0, 1, -1, 32'h00000005);
      checks++;
      if (cyc_seen !== 1'b1) begin
         failures++; $display("FAIL way0_replaced cyc=%b expected 1", cyc_seen);
      end
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; req = 1'b0; we = 1'b0; adr = '0; dat = '0;
      mem_rdata = '0; mem_ack = 1'b0; mem_err = 1'b0;
      test_reset();
      test_cold_miss();
      test_back_to_back();
      test_dirty_eviction();
      test_write_through();
      test_mem_error();
      test_reset_mid_fill();
      test_clean_eviction();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
